pe_driver: RTL and testbench

PE_DRIVER -- requirements
Module: pe_driver

---
 rtl/pe_driver.sv | 195 +++++++++++++++++++
 tb/tb_pe_driver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pe_driver.sv
// rtl/pe_driver.sv - sequences weight and activation streams into a PE and captures one result per neuron.
// Optional macro PE_DRIVER_PRELOAD_EN: load the next neuron's weights while the current neuron runs.
module pe_driver #(
    parameter int INPUT_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int INPUT_NUM    = 4,
    parameter int NEURON_NUM   = 2,
    parameter int PE_OUT_WIDTH = 8,
    parameter int PE_LATENCY   = 2,
    localparam int NW = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [WEIGHT_WIDTH-1:0] w_data,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic [INPUT_WIDTH-1:0]  x_data,
    output logic                    new_weight,
    output logic [WEIGHT_WIDTH-1:0] weight,
    output logic                    input_available,
    output logic [INPUT_WIDTH-1:0]  input_data,
    input  logic [PE_OUT_WIDTH-1:0] pe_out,
    output logic                    result_valid,
    output logic [PE_OUT_WIDTH-1:0] result,
    output logic [NW-1:0]           result_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = $clog2(INPUT_NUM + 1);
    localparam int DW = (PE_LATENCY > 0) ? $clog2(PE_LATENCY + 1) : 1;

    localparam logic [CW-1:0] LAST_BEAT   = CW'(INPUT_NUM - 1);
    localparam logic [NW-1:0] LAST_NEURON = NW'(NEURON_NUM - 1);
    localparam logic [DW-1:0] DRAIN_LAST  = DW'((PE_LATENCY > 0) ? PE_LATENCY - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [CW-1:0]           w_cnt_q, w_cnt_d;
    logic [CW-1:0]           x_cnt_q, x_cnt_d;
    logic [NW-1:0]           n_cnt_q, n_cnt_d;
    logic [DW-1:0]           d_cnt_q, d_cnt_d;
    logic                    new_weight_q;
    logic [WEIGHT_WIDTH-1:0] weight_q, weight_d;
    logic                    input_available_q;
    logic [INPUT_WIDTH-1:0]  input_data_q, input_data_d;
    logic                    result_valid_q;
    logic [PE_OUT_WIDTH-1:0] result_q, result_d;
    logic [NW-1:0]           result_idx_q, result_idx_d;
    logic                    done_q;

    logic w_hs, x_hs, w_last, x_last, last_neuron, bank_ready;

`ifdef PE_DRIVER_PRELOAD_EN
    logic wbank_full_q, wbank_full_d;

    // Preload only targets neurons that still follow the current one.
    assign w_ready = (state_q == S_LOAD) ||
                     (((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                      (n_cnt_q != LAST_NEURON) && !wbank_full_q);
    assign bank_ready = wbank_full_q;

    always_comb begin
        wbank_full_d = wbank_full_q;
        if (state_q == S_EMIT) begin
            wbank_full_d = 1'b0;
        end else if (w_last && (state_q != S_LOAD)) begin
            wbank_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbank_full_q <= 1'b0;
        end else begin
            wbank_full_q <= wbank_full_d;
        end
    end
`else
    assign w_ready    = (state_q == S_LOAD);
    assign bank_ready = 1'b0;
`endif

    assign x_ready     = (state_q == S_RUN);
    assign w_hs        = w_valid & w_ready;
    assign x_hs        = x_valid & x_ready;
    assign w_last      = w_hs && (w_cnt_q == LAST_BEAT);
    assign x_last      = x_hs && (x_cnt_q == LAST_BEAT);
    assign last_neuron = (n_cnt_q == LAST_NEURON);

    always_comb begin
        state_d      = state_q;
        n_cnt_d      = n_cnt_q;
        d_cnt_d      = d_cnt_q;
        w_cnt_d      = w_cnt_q;
        x_cnt_d      = x_cnt_q;
        weight_d     = weight_q;
        input_data_d = input_data_q;
        result_d     = result_q;
        result_idx_d = result_idx_q;

        if (w_hs) begin
            w_cnt_d  = w_last ? '0 : w_cnt_q + CW'(1);
            weight_d = w_data;
        end
        if (x_hs) begin
            x_cnt_d      = x_last ? '0 : x_cnt_q + CW'(1);
            input_data_d = x_data;
        end

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (w_last) state_d = S_RUN;
            end
            S_RUN: begin
                if (x_last) state_d = (PE_LATENCY == 0) ? S_EMIT : S_DRAIN;
            end
            S_DRAIN: begin
                d_cnt_d = d_cnt_q + DW'(1);
                if (d_cnt_q == DRAIN_LAST) begin
                    d_cnt_d = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                result_d     = pe_out;
                result_idx_d = n_cnt_q;
                n_cnt_d      = last_neuron ? '0 : n_cnt_q + NW'(1);
                if (last_neuron) begin
                    state_d = S_IDLE;
                end else if (bank_ready) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            w_cnt_q           <= '0;
            x_cnt_q           <= '0;
            n_cnt_q           <= '0;
            d_cnt_q           <= '0;
            new_weight_q      <= 1'b0;
            weight_q          <= '0;
            input_available_q <= 1'b0;
            input_data_q      <= '0;
            result_valid_q    <= 1'b0;
            result_q          <= '0;
            result_idx_q      <= '0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            w_cnt_q           <= w_cnt_d;
            x_cnt_q           <= x_cnt_d;
            n_cnt_q           <= n_cnt_d;
            d_cnt_q           <= d_cnt_d;
            new_weight_q      <= w_hs;
            weight_q          <= weight_d;
            input_available_q <= x_hs;
            input_data_q      <= input_data_d;
            result_valid_q    <= (state_q == S_EMIT);
            result_q          <= result_d;
            result_idx_q      <= result_idx_d;
            done_q            <= (state_q == S_EMIT) && last_neuron;
        end
    end

    // Result and done leave the cycle after EMIT; busy drops as done rises.
    assign new_weight      = new_weight_q;
    assign weight          = weight_q;
    assign input_available = input_available_q;
    assign input_data      = input_data_q;
    assign result_valid    = result_valid_q;
    assign result          = result_q;
    assign result_idx      = result_idx_q;
    assign done            = done_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_driver.sv
// tb/tb_pe_driver.sv - directed bench for pe_driver (default and single-beat configurations).
module tb_pe_driver;

`ifdef PE_DRIVER_PRELOAD_EN
    localparam int         EXP_DONE   = 19;
    localparam logic [7:0] EXP_RES1   = 8'h52;
    localparam int         EXP_DONE_X = 25;
    localparam logic       EXP_OVL    = 1'b1;
`else
    localparam int         EXP_DONE   = 23;
    localparam logic [7:0] EXP_RES1   = 8'h56;
    localparam int         EXP_DONE_X = 29;
    localparam logic       EXP_OVL    = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, w_valid, x_valid;
    logic [7:0] w_data, x_data, pe_out;

    logic       a_w_ready, a_x_ready, a_nw, a_ia, a_rv, a_busy, a_done;
    logic [7:0] a_weight, a_input, a_result;
    logic       a_idx;
    logic       b_w_ready, b_x_ready, b_nw, b_ia, b_rv, b_busy, b_done;
    logic [7:0] b_weight, b_input, b_result;
    logic       b_idx;

    always #5 clk = ~clk;

    pe_driver dut_a (
        .clk(clk), .reset(reset), .start(start),
        .w_valid(w_valid), .w_ready(a_w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(a_x_ready), .x_data(x_data),
        .new_weight(a_nw), .weight(a_weight),
        .input_available(a_ia), .input_data(a_input),
        .pe_out(pe_out), .result_valid(a_rv), .result(a_result), .result_idx(a_idx),
        .busy(a_busy), .done(a_done)
    );

    pe_driver #(.INPUT_NUM(1), .NEURON_NUM(1)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .w_valid(w_valid), .w_ready(b_w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(b_x_ready), .x_data(x_data),
        .new_weight(b_nw), .weight(b_weight),
        .input_available(b_ia), .input_data(b_input),
        .pe_out(pe_out), .result_valid(b_rv), .result(b_result), .result_idx(b_idx),
        .busy(b_busy), .done(b_done)
    );

    int checks = 0;
    int errors = 0;

    logic       tr_nw [0:63];
    logic       tr_ia [0:63];
    logic       tr_busy [0:63];
    logic       tr_wr [0:63];
    logic       tr_xr [0:63];
    logic [7:0] tr_w [0:63];
    logic [7:0] tr_x [0:63];
    int         nw_cnt, ia_cnt, rv_cnt, dn_cnt, done_cyc;
    int         rv_cyc [0:3];
    logic [7:0] rv_res [0:3];
    logic       rv_idx [0:3];
    int         b_done_cyc, b_rv_cnt;
    logic [7:0] b_res, b_w_first;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle c is the clock period after edge c-1; inputs set in cycle c are sampled at edge c.
    task automatic run(input int max_cyc, input bit xpat, input int start2_cyc, input int rst_cyc);
        logic w_hs, x_hs;
        nw_cnt = 0; ia_cnt = 0; rv_cnt = 0; dn_cnt = 0; done_cyc = -1;
        b_done_cyc = -1; b_rv_cnt = 0; b_res = 8'h00; b_w_first = 8'h00;
        for (int i = 0; i < 64; i++) begin
            tr_nw[i] = 0; tr_ia[i] = 0; tr_busy[i] = 0; tr_wr[i] = 0; tr_xr[i] = 0;
            tr_w[i] = 0; tr_x[i] = 0;
        end
        start = 1'b1; w_valid = 1'b1; x_valid = 1'b1;
        w_data = 8'h01; x_data = 8'h11; pe_out = 8'h40;
        w_hs = 1'b0; x_hs = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk);
            #1;
            if (w_hs) w_data = w_data + 8'h01;
            if (x_hs) x_data = x_data + 8'h01;
            tr_nw[c] = a_nw; tr_ia[c] = a_ia; tr_busy[c] = a_busy;
            tr_wr[c] = a_w_ready; tr_xr[c] = a_x_ready;
            tr_w[c] = a_weight; tr_x[c] = a_input;
            if (a_nw) nw_cnt++;
            if (a_ia) ia_cnt++;
            if (a_rv) begin
                if (rv_cnt < 4) begin
                    rv_cyc[rv_cnt] = c; rv_res[rv_cnt] = a_result; rv_idx[rv_cnt] = a_idx;
                end
                rv_cnt++;
            end
            if (a_done) begin
                dn_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (b_nw && b_w_first == 8'h00) b_w_first = b_weight;
            if (b_rv) begin b_rv_cnt++; b_res = b_result; end
            if (b_done && b_done_cyc < 0) b_done_cyc = c;
            start   = (c == start2_cyc);
            reset   = (c == rst_cyc);
            x_valid = xpat ? c[0] : 1'b1;
            pe_out  = 8'h40 + 8'(c);
            w_hs    = w_valid & a_w_ready;
            x_hs    = x_valid & a_x_ready;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0; reset = 1'b0; w_valid = 1'b0; x_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  v4;
    logic [6:0]  v7;
    logic [31:0] v32;

    initial begin
        reset = 1'b1; start = 1'b0; w_valid = 1'b0; x_valid = 1'b0;
        w_data = 8'h00; x_data = 8'h00; pe_out = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {a_nw, a_ia, a_rv, a_busy, a_done, a_w_ready, a_x_ready, a_idx}, 32'h0);
        chk("rst_data", {a_weight, a_input, a_result}, 32'h0);
        reset = 1'b0;

        // Default stream, no stalls.
        run(40, 1'b0, -1, -1);
        for (int i = 0; i < 4; i++) v4[3-i] = tr_nw[2+i];
        chk("w_beats_consecutive", v4, 4'hF);
        chk("w_bubble_after", tr_nw[1], 1'b0);
        for (int i = 0; i < 4; i++) v32[31-8*i -: 8] = tr_w[2+i];
        chk("weights", v32, 32'h01020304);
        for (int i = 0; i < 4; i++) v4[3-i] = tr_ia[6+i];
        chk("x_beats_consecutive", v4, 4'hF);
        chk("x_none_after", tr_ia[10], 1'b0);
        for (int i = 0; i < 4; i++) v32[31-8*i -: 8] = tr_x[6+i];
        chk("inputs", v32, 32'h11121314);
        chk("preload_overlap", tr_nw[6], EXP_OVL);
        chk("nw_total", nw_cnt, 8);
        chk("rv_count", rv_cnt, 2);
        chk("rv0_cycle", rv_cyc[0], 12);
        chk("rv0_result", rv_res[0], 8'h4B);
        chk("rv0_idx", rv_idx[0], 1'b0);
        chk("rv1_cycle", rv_cyc[1], EXP_DONE);
        chk("rv1_result", rv_res[1], EXP_RES1);
        chk("rv1_idx", rv_idx[1], 1'b1);
        chk("done_count", dn_cnt, 1);
        chk("done_cycle", done_cyc, EXP_DONE);
        chk("busy_running", {tr_busy[1], tr_busy[EXP_DONE-1]}, 2'b11);
        chk("busy_after_done", tr_busy[EXP_DONE], 1'b0);
        chk("w_ready_emit", tr_wr[11], 1'b0);
        chk("x_ready_drain", tr_xr[9], 1'b0);
        chk("b_done_cycle", b_done_cyc, 6);
        chk("b_result", {b_rv_cnt[7:0], b_res, b_w_first}, {8'd1, 8'h45, 8'h01});

        // Input stream valid every other cycle.
        run(40, 1'b1, -1, -1);
        for (int i = 0; i < 7; i++) v7[6-i] = tr_ia[6+i];
        chk("x_stall_pattern", v7, 7'b1010101);
        chk("x_stall_rv0", {rv_cyc[0][7:0], rv_res[0]}, {8'd15, 8'h4E});
        chk("x_stall_done", done_cyc, EXP_DONE_X);

        // Start pulsed while busy is ignored.
        run(40, 1'b0, 3, -1);
        chk("restart_rv_count", rv_cnt, 2);
        chk("restart_done", {dn_cnt[7:0], done_cyc[7:0]}, {8'd1, 8'(EXP_DONE)});
        chk("restart_idle", tr_busy[EXP_DONE+1], 1'b0);
        chk("restart_b", b_rv_cnt, 1);

        // Reset in RUN after two input beats.
        run(14, 1'b0, -1, 7);
        chk("abort_before", tr_ia[7], 1'b1);
        chk("abort_outputs", {tr_nw[8], tr_ia[8], tr_busy[8], tr_wr[8], tr_xr[8]}, 5'b0);
        chk("abort_data", {tr_w[8], tr_x[8]}, 16'h0);
        chk("abort_no_replay", ia_cnt, 2);
        chk("abort_no_done", {rv_cnt[7:0], dn_cnt[7:0]}, 16'h0);

        // Fresh run completes normally; single-beat instance wraps its counters.
        run(40, 1'b0, -1, -1);
        chk("fresh_done", done_cyc, EXP_DONE);
        chk("fresh_results", {rv_cnt[7:0], rv_res[0], rv_res[1]}, {8'd2, 8'h4B, EXP_RES1});
        chk("b_second_done", b_done_cyc, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
